uart_rx_cfg: RTL and testbench

//   Parametrised UART receiver: configurable data width, parity and stop bits.
//   2-flop input synchroniser, falling-edge start detect, 3-sample majority vote.

---
 rtl/uart_rx_cfg.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg -- parametrised UART receiver
//
// Purpose
//   Receives asynchronous serial frames from an external RX pin:
//   start bit, DATA_BITS data bits (LSB first), optional parity bit and
//   STOP_BITS stop bits.
//   - The pin goes through a 2-flop synchroniser that resets to 1 (line idle).
//   - A 1 -> 0 edge on the synchronised line starts a frame.
//   - Each bit is sampled three times around mid-bit and decided by
//     majority vote.
//   - The received word goes into a holding register with a valid/ack
//     handshake.
//   - Framing, parity and overrun problems are reported as single-cycle
//     pulses.
//
// Optional feature (compile-time macro UART_RX_BREAK_DETECT_EN)
//   When the macro is defined, a frame with all data bits 0 and all stop
//   votes 0 is a line break:
//   - brk pulses together with frame_err.
//   - Nothing is loaded and no overrun is reported.
//   - The receiver waits for BIT_PERIOD consecutive idle-high clocks before
//     it re-arms.
//   When the macro is undefined, brk is tied 0 and such frames are ordinary
//   framing errors.
//
// Ports
//   clk         in   1          system clock
//   reset       in   1          asynchronous, active-high reset
//   rx          in   1          serial line, idle high, asynchronous to clk
//   data_out    out  DATA_BITS  received word, stable while data_valid=1
//   data_valid  out  1          holding register full until data_ack
//   data_ack    in   1          consumer accepted data_out
//   frame_err   out  1          1-cycle pulse: a stop-bit vote was 0
//   parity_err  out  1          1-cycle pulse: parity mismatch
//   overrun     out  1          1-cycle pulse: frame completed while full
//   brk         out  1          1-cycle pulse: line break detected
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int SYS_CLK_FREQ = 48_000_000,
   parameter int BAUD_RATE    = 9_600,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ack,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 brk
);

   localparam int BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
   localparam int HALF       = BIT_PERIOD / 2;
   localparam int CW         = $clog2(BIT_PERIOD);
   localparam int IW         = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_SMP_A = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_SMP_B = CW'(HALF);
   localparam logic [CW-1:0] CNT_DEC   = CW'(HALF + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_STOP     = 3'd4,
      ST_BRK_WAIT = 3'd5
   } state_e;

   // majority of three samples
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // parity bit the transmitter should have sent for word w
   function automatic logic exp_parity(input logic [DATA_BITS-1:0] w);
      if (PARITY == 1) begin
         return ~(^w);
      end else begin
         return ^w;
      end
   endfunction

   // synchroniser and edge detect
   logic sync1_q, sync2_q, rx_prev_q;
   logic rx_s, fall_s;

   // FSM and bit timing
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            stop_idx_q, stop_idx_d;
   logic            smp_a_q, smp_a_d;
   logic            smp_b_q, smp_b_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic            par_bad_q, par_bad_d;
   logic            stop_zero_q, stop_zero_d;
   logic            vote_s, decide_s, bit_end_s;
   logic            load_s;

   // output registers
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic            data_valid_q, data_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            parity_err_q, parity_err_d;
   logic            overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
   logic            stop_one_q, stop_one_d;
   logic            brk_q, brk_d;
`endif

   assign rx_s      = sync2_q;
   assign fall_s    = rx_prev_q & ~rx_s;
   assign decide_s  = (cnt_q == CNT_DEC);
   assign bit_end_s = (cnt_q == CNT_LAST);
   // third sample is the live synchronised line at the decision count
   assign vote_s    = maj3(smp_a_q, smp_b_q, rx_s);

   // next-state logic: FSM, bit timer, sampling, frame resolution
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      stop_idx_d   = stop_idx_q;
      shreg_d      = shreg_q;
      par_bad_d    = par_bad_q;
      stop_zero_d  = stop_zero_q;
      data_out_d   = data_out_q;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      load_s       = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      stop_one_d   = stop_one_q;
      brk_d        = 1'b0;
`endif

      // ack frees the holding register; a same-cycle load below overrides
      if (data_valid_q && data_ack) begin
         data_valid_d = 1'b0;
      end else begin
         data_valid_d = data_valid_q;
      end

      // free-running bit timer, wrapped at the end of each bit
      if (bit_end_s) begin
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end

      if (cnt_q == CNT_SMP_A) begin
         smp_a_d = rx_s;
      end else begin
         smp_a_d = smp_a_q;
      end
      if (cnt_q == CNT_SMP_B) begin
         smp_b_d = rx_s;
      end else begin
         smp_b_d = smp_b_q;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = {CW{1'b0}};
            if (fall_s) begin
               state_d     = ST_START;
               idx_d       = {IW{1'b0}};
               stop_idx_d  = 1'b0;
               par_bad_d   = 1'b0;
               stop_zero_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
               stop_one_d  = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_START: begin
            if (decide_s && vote_s) begin
               state_d = ST_IDLE;           // glitch, not a start bit
            end else if (bit_end_s) begin
               state_d = ST_DATA;
               idx_d   = {IW{1'b0}};
            end else begin
               state_d = ST_START;
            end
         end

         ST_DATA: begin
            // LSB arrives first, so after DATA_BITS right shifts it sits at bit 0
            if (decide_s) begin
               shreg_d = {vote_s, shreg_q[DATA_BITS-1:1]};
            end else begin
               shreg_d = shreg_q;
            end
            if (bit_end_s) begin
               if (idx_q == IDX_LAST) begin
                  if (PARITY != 0) begin
                     state_d = ST_PARITY;
                  end else begin
                     state_d = ST_STOP;
                  end
                  stop_idx_d = 1'b0;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               idx_d = idx_q;
            end
         end

         ST_PARITY: begin
            if (decide_s) begin
               par_bad_d = (vote_s != exp_parity(shreg_q));
            end else begin
               par_bad_d = par_bad_q;
            end
            if (bit_end_s) begin
               state_d    = ST_STOP;
               stop_idx_d = 1'b0;
            end else begin
               state_d = ST_PARITY;
            end
         end

         ST_STOP: begin
            if (decide_s && (stop_idx_q == STOP_LAST)) begin
               // final stop vote: resolve the frame and leave early so a
               // back-to-back start edge half a bit later is not missed
               state_d = ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
               if ((shreg_q == {DATA_BITS{1'b0}}) && !(stop_one_q || vote_s)) begin
                  brk_d       = 1'b1;
                  frame_err_d = 1'b1;
                  state_d     = ST_BRK_WAIT;
                  cnt_d       = {CW{1'b0}};
               end else begin
                  frame_err_d  = stop_zero_q | ~vote_s;
                  parity_err_d = par_bad_q;
                  load_s       = 1'b1;
               end
`else
               frame_err_d  = stop_zero_q | ~vote_s;
               parity_err_d = par_bad_q;
               load_s       = 1'b1;
`endif
            end else if (decide_s) begin
               stop_zero_d = stop_zero_q | ~vote_s;
`ifdef UART_RX_BREAK_DETECT_EN
               stop_one_d  = stop_one_q | vote_s;
`endif
            end else if (bit_end_s) begin
               stop_idx_d = 1'b1;
            end else begin
               state_d = ST_STOP;
            end
         end

`ifdef UART_RX_BREAK_DETECT_EN
         ST_BRK_WAIT: begin
            // re-arm only after a full bit period of continuous idle
            if (!rx_s) begin
               cnt_d = {CW{1'b0}};
            end else if (bit_end_s) begin
               cnt_d   = {CW{1'b0}};
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase

      // holding register: an ack in the same cycle makes room first
      if (load_s) begin
         if (!data_valid_q || data_ack) begin
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else begin
         data_out_d = data_out_q;
      end
   end

   // state and output registers, async reset to line-idle / empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= ST_IDLE;
         cnt_q        <= {CW{1'b0}};
         idx_q        <= {IW{1'b0}};
         stop_idx_q   <= 1'b0;
         smp_a_q      <= 1'b1;
         smp_b_q      <= 1'b1;
         shreg_q      <= {DATA_BITS{1'b0}};
         par_bad_q    <= 1'b0;
         stop_zero_q  <= 1'b0;
         data_out_q   <= {DATA_BITS{1'b0}};
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         stop_one_q   <= 1'b0;
         brk_q        <= 1'b0;
`endif
      end else begin
         sync1_q      <= rx;
         sync2_q      <= sync1_q;
         rx_prev_q    <= sync2_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         stop_idx_q   <= stop_idx_d;
         smp_a_q      <= smp_a_d;
         smp_b_q      <= smp_b_d;
         shreg_q      <= shreg_d;
         par_bad_q    <= par_bad_d;
         stop_zero_q  <= stop_zero_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
         stop_one_q   <= stop_one_d;
         brk_q        <= brk_d;
`endif
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
`ifdef UART_RX_BREAK_DETECT_EN
   assign brk        = brk_q;
`else
   assign brk        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg -- self-checking bench for uart_rx_cfg
//   dut8 : 8N1 receiver, dut7 : 7 data bits, even parity, 1 stop.
//   Both run at BIT_PERIOD = 16 clocks.
//   A vector table covers single frames; hand-written sequences cover
//   back-to-back overrun, glitch rejection, long break and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

   localparam int BP = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx8 = 1'b1, rx7 = 1'b1;
   logic       ack8 = 1'b0, ack7 = 1'b0;
   logic [7:0] do8;
   logic [6:0] do7;
   logic       dv8, fe8, pe8, ov8, bk8;
   logic       dv7, fe7, pe7, ov7, bk7;

   int n_total = 0;
   int n_pass  = 0;

   // pulse counters per DUT (index 0 = dut8, 1 = dut7)
   int fe_c[2] = '{0, 0};
   int pe_c[2] = '{0, 0};
   int ov_c[2] = '{0, 0};
   int bk_c[2] = '{0, 0};
   int fe_s[2], pe_s[2], ov_s[2], bk_s[2];

   uart_rx_cfg #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1)) dut8 (
      .clk(clk), .reset(reset), .rx(rx8), .data_out(do8), .data_valid(dv8),
      .data_ack(ack8), .frame_err(fe8), .parity_err(pe8), .overrun(ov8), .brk(bk8));

   uart_rx_cfg #(.SYS_CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(1)) dut7 (
      .clk(clk), .reset(reset), .rx(rx7), .data_out(do7), .data_valid(dv7),
      .data_ack(ack7), .frame_err(fe7), .parity_err(pe7), .overrun(ov7), .brk(bk7));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fe8) fe_c[0] <= fe_c[0] + 1;
      if (pe8) pe_c[0] <= pe_c[0] + 1;
      if (ov8) ov_c[0] <= ov_c[0] + 1;
      if (bk8) bk_c[0] <= bk_c[0] + 1;
      if (fe7) fe_c[1] <= fe_c[1] + 1;
      if (pe7) pe_c[1] <= pe_c[1] + 1;
      if (ov7) ov_c[1] <= ov_c[1] + 1;
      if (bk7) bk_c[1] <= bk_c[1] + 1;
   end

   typedef struct {
      bit       sel;       // 0: dut8, 1: dut7
      bit [7:0] data;
      bit       par;       // parity bit sent (dut7 only)
      bit       stop;
      bit [7:0] exp_data;
      bit       exp_fe;
      bit       exp_pe;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic cur_dv(input bit sel);
      return sel ? dv7 : dv8;
   endfunction

   function automatic logic [7:0] cur_do(input bit sel);
      return sel ? {1'b0, do7} : do8;
   endfunction

   task automatic snap();
      for (int k = 0; k < 2; k++) begin
         fe_s[k] = fe_c[k]; pe_s[k] = pe_c[k]; ov_s[k] = ov_c[k]; bk_s[k] = bk_c[k];
      end
   endtask

   task automatic drive_bit(input bit sel, input logic v);
      if (sel) rx7 = v; else rx8 = v;
      repeat (BP) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit sel, input bit [7:0] d, input bit par,
                             input bit stop, input bit gap);
      drive_bit(sel, 1'b0);
      for (int b = 0; b < (sel ? 7 : 8); b++) drive_bit(sel, d[b]);
      if (sel) drive_bit(sel, par);
      drive_bit(sel, stop);
      if (gap) drive_bit(sel, 1'b1);
   endtask

   task automatic wait_valid(input bit sel, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (cur_dv(sel)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_ack(input bit sel);
      @(posedge clk); #1;
      if (sel) ack7 = 1'b1; else ack8 = 1'b1;
      @(posedge clk); #1;
      if (sel) ack7 = 1'b0; else ack8 = 1'b0;
      @(negedge clk);
      chk("ack_clears_valid", cur_dv(sel), 1'b0);
   endtask

   initial begin
      bit ok;

      vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1};
      vecs[5] = '{1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
      vecs[6] = '{1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[7] = '{1, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
      vecs[8] = '{1, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};

      // reset state
      #12;
      chk("rst_valid", dv8, 1'b0);
      chk("rst_data", do8, 8'h00);
      chk("rst_pulses", {fe8, pe8, ov8, bk8}, 4'b0000);
      chk("rst_valid7", dv7, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk); #1;

      // table of single frames
      for (int i = 0; i < 9; i++) begin
         snap();
         send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop, 1'b1);
         wait_valid(vecs[i].sel, 64, ok);
         chk($sformatf("v%0d_valid", i), ok, 1'b1);
         chk($sformatf("v%0d_data", i), cur_do(vecs[i].sel), vecs[i].exp_data);
         chk($sformatf("v%0d_fe", i), fe_c[vecs[i].sel] - fe_s[vecs[i].sel], vecs[i].exp_fe);
         chk($sformatf("v%0d_pe", i), pe_c[vecs[i].sel] - pe_s[vecs[i].sel], vecs[i].exp_pe);
         chk($sformatf("v%0d_ov", i), ov_c[vecs[i].sel] - ov_s[vecs[i].sel], 0);
         do_ack(vecs[i].sel);
      end

      // back-to-back frames without ack: first word kept, one overrun
      snap();
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("b2b_valid", dv8, 1'b1);
      chk("b2b_data", do8, 8'h11);
      chk("b2b_ov", ov_c[0] - ov_s[0], 1);
      chk("b2b_fe", fe_c[0] - fe_s[0], 0);
      do_ack(0);

      // 4-clock low glitch is rejected, receiver still idle afterwards
      snap();
      rx8 = 1'b0;
      repeat (4) @(posedge clk); #1;
      rx8 = 1'b1;
      repeat (3 * BP) @(posedge clk);
      @(negedge clk);
      chk("glitch_valid", dv8, 1'b0);
      chk("glitch_pulses", (fe_c[0] - fe_s[0]) + (ov_c[0] - ov_s[0]), 0);
      @(posedge clk); #1;
      send_frame(0, 8'h96, 1'b0, 1'b1, 1'b1);
      wait_valid(0, 64, ok);
      chk("glitch_next_valid", ok, 1'b1);
      chk("glitch_next_data", do8, 8'h96);
      do_ack(0);

      // line held low for 20 bit periods
      snap();
      @(posedge clk); #1;
      rx8 = 1'b0;
      repeat (20 * BP) @(posedge clk); #1;
`ifdef UART_RX_BREAK_DETECT_EN
      // short high burst must not re-arm the receiver
      rx8 = 1'b1;
      repeat (8) @(posedge clk); #1;
      rx8 = 1'b0;
      repeat (12 * BP) @(posedge clk); #1;
      rx8 = 1'b1;
      repeat (3 * BP) @(posedge clk);
      @(negedge clk);
      chk("brk_pulse", bk_c[0] - bk_s[0], 1);
      chk("brk_fe", fe_c[0] - fe_s[0], 1);
      chk("brk_valid", dv8, 1'b0);
      chk("brk_ov", ov_c[0] - ov_s[0], 0);
`else
      rx8 = 1'b1;
      repeat (3 * BP) @(posedge clk);
      @(negedge clk);
      chk("brk_pulse", bk_c[0] - bk_s[0], 0);
      chk("brk_fe", fe_c[0] - fe_s[0], 1);
      chk("brk_valid", dv8, 1'b1);
      chk("brk_data", do8, 8'h00);
      do_ack(0);
`endif

      // reset in the middle of the data bits
      @(posedge clk); #1;
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("prerst_valid", dv8, 1'b1);
      @(posedge clk); #1;
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b1);
      rx8 = 1'b0;
      repeat (5) @(posedge clk); #1;
      reset = 1'b1;
      #2;
      chk("midrst_valid", dv8, 1'b0);
      chk("midrst_data", do8, 8'h00);
      rx8 = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2 * BP) @(posedge clk); #1;
      snap();
      send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
      wait_valid(0, 64, ok);
      chk("postrst_valid", ok, 1'b1);
      chk("postrst_data", do8, 8'h5A);
      chk("postrst_fe", fe_c[0] - fe_s[0], 0);
      do_ack(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
